// File: rtl/route_pkg.sv
// Shared types and phase-selection helpers for the route_seq mux sequencer.
package route_pkg;

  // Widest beat count the helpers accept; callers zero-extend narrower lens.
  localparam int MAX_CNT_W = 16;

  typedef enum logic [1:0] {
    SEL_SRC0 = 2'b00,
    SEL_SRC1 = 2'b01,
    SEL_SRC2 = 2'b10,
    SEL_NONE = 2'b11
  } sel_t;

  typedef enum logic [2:0] {
    IDLE,
    SRC0,
    SRC1,
    SRC2,
    FIN
  } state_t;

  // First phase after 'state' whose length is nonzero; FIN when none remain.
  function automatic state_t next_phase(input state_t                 state,
                                        input logic [MAX_CNT_W-1:0] len0,
                                        input logic [MAX_CNT_W-1:0] len1,
                                        input logic [MAX_CNT_W-1:0] len2);
    state_t nxt;
    nxt = FIN;
    case (state)
      IDLE: begin
        if (len0 != '0)      nxt = SRC0;
        else if (len1 != '0) nxt = SRC1;
        else if (len2 != '0) nxt = SRC2;
      end
      SRC0: begin
        if (len1 != '0)      nxt = SRC1;
        else if (len2 != '0) nxt = SRC2;
      end
      SRC1: begin
        if (len2 != '0)      nxt = SRC2;
      end
      default: nxt = FIN;
    endcase
    return nxt;
  endfunction

  // Mux select that goes with a streaming phase.
  function automatic sel_t phase_sel(input state_t s);
    case (s)
      SRC0:    return SEL_SRC0;
      SRC1:    return SEL_SRC1;
      SRC2:    return SEL_SRC2;
      default: return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/route_beat_counter.sv
// Up-counter with clear priority and an equality flag against a limit.
module route_beat_counter #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             at_limit
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + CNT_W'(1);
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt      = cnt_q;
  assign at_limit = (cnt_q == limit);

endmodule

// File: rtl/route_seq.sv
// Sequencer for the 3:1 word mux: streams len0/len1/len2 beats from sources
// 0/1/2 under valid/ready, with a registered sel/addr/last per beat.
// Optional build macro ROUTE_SEQ_REPEAT_EN adds a 'reps' input that repeats
// the whole pass back-to-back.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// SRC0  | streaming source 0 (input pixels)
// SRC1  | streaming source 1 (hidden activations)
// SRC2  | streaming source 2 (bias/weights)
// FIN   | one cycle after the pass; done shown here (or on exit for empty pass)
module route_seq
  import route_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len0,
  input  logic [CNT_W-1:0] len1,
  input  logic [CNT_W-1:0] len2,
`ifdef ROUTE_SEQ_REPEAT_EN
  input  logic [CNT_W-1:0] reps,
`endif
  input  logic             ready,
  output logic [1:0]       sel,
  output logic [CNT_W-1:0] addr,
  output logic             valid,
  output logic             last,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d, nxt;
  sel_t             sel_q, sel_d;
  logic             valid_q, valid_d, last_q, last_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0] len0_q, len0_d, len1_q, len1_d, len2_q, len2_d;
  logic [CNT_W-1:0] cur_len, addr_cnt, addr_limit;
  logic             addr_clr, addr_inc, addr_at_limit;
  logic             rep_last, rep_next_last, start_one_pass;

  // True when beat 'a' of phase 'p' is the final beat of the final pass.
  function automatic logic final_beat(input state_t p, input logic [CNT_W-1:0] a,
                                      input logic [CNT_W-1:0] l0, input logic [CNT_W-1:0] l1,
                                      input logic [CNT_W-1:0] l2, input logic rl);
    logic [CNT_W-1:0] lp;
    case (p)
      SRC0:    lp = l0;
      SRC1:    lp = l1;
      SRC2:    lp = l2;
      default: lp = '0;
    endcase
    return rl && (lp != '0) && (a == lp - CNT_W'(1)) &&
           (next_phase(p, MAX_CNT_W'(l0), MAX_CNT_W'(l1), MAX_CNT_W'(l2)) == FIN);
  endfunction

  // Length of the phase currently streaming.
  always_comb begin
    case (state_q)
      SRC0:    cur_len = len0_q;
      SRC1:    cur_len = len1_q;
      SRC2:    cur_len = len2_q;
      default: cur_len = '0;
    endcase
  end

  assign addr_limit = cur_len - CNT_W'(1);

  route_beat_counter #(.CNT_W(CNT_W)) u_addr (
    .clk      (clk),
    .reset    (reset),
    .clr      (addr_clr),
    .inc      (addr_inc),
    .limit    (addr_limit),
    .cnt      (addr_cnt),
    .at_limit (addr_at_limit)
  );

`ifdef ROUTE_SEQ_REPEAT_EN
  logic [CNT_W-1:0] reps_q, reps_d, reps_in_eff, rep_cnt, rep_limit;
  logic             rep_clr, rep_inc;

  // A request for zero repetitions still runs one pass.
  assign reps_in_eff    = (reps == '0) ? CNT_W'(1) : reps;
  assign start_one_pass = (reps_in_eff == CNT_W'(1));
  assign rep_limit      = reps_q - CNT_W'(1);
  assign rep_next_last  = ((rep_cnt + CNT_W'(1)) == rep_limit);

  route_beat_counter #(.CNT_W(CNT_W)) u_rep (
    .clk      (clk),
    .reset    (reset),
    .clr      (rep_clr),
    .inc      (rep_inc),
    .limit    (rep_limit),
    .cnt      (rep_cnt),
    .at_limit (rep_last)
  );
`else
  assign start_one_pass = 1'b1;
  assign rep_last       = 1'b1;
  assign rep_next_last  = 1'b1;
`endif

  // Next-state and next-output logic; outputs describe the beat shown next cycle.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    valid_d  = valid_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    len0_d   = len0_q;
    len1_d   = len1_q;
    len2_d   = len2_q;
    addr_clr = 1'b0;
    addr_inc = 1'b0;
    nxt      = FIN;
`ifdef ROUTE_SEQ_REPEAT_EN
    reps_d   = reps_q;
    rep_clr  = 1'b0;
    rep_inc  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        sel_d   = SEL_NONE;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          len0_d   = len0;
          len1_d   = len1;
          len2_d   = len2;
          busy_d   = 1'b1;
          addr_clr = 1'b1;
`ifdef ROUTE_SEQ_REPEAT_EN
          reps_d   = reps_in_eff;
          rep_clr  = 1'b1;
`endif
          nxt     = next_phase(IDLE, MAX_CNT_W'(len0), MAX_CNT_W'(len1), MAX_CNT_W'(len2));
          state_d = nxt;
          if (nxt != FIN) begin
            valid_d = 1'b1;
            sel_d   = phase_sel(nxt);
            last_d  = final_beat(nxt, '0, len0, len1, len2, start_one_pass);
          end
        end
      end
      SRC0, SRC1, SRC2: begin
        if (valid_q && ready) begin
          if (!addr_at_limit) begin
            addr_inc = 1'b1;
            last_d   = final_beat(state_q, addr_cnt + CNT_W'(1), len0_q, len1_q, len2_q, rep_last);
          end else begin
            addr_clr = 1'b1;
            nxt = next_phase(state_q, MAX_CNT_W'(len0_q), MAX_CNT_W'(len1_q), MAX_CNT_W'(len2_q));
            if (nxt != FIN) begin
              state_d = nxt;
              sel_d   = phase_sel(nxt);
              last_d  = final_beat(nxt, '0, len0_q, len1_q, len2_q, rep_last);
            end else if (!rep_last) begin
`ifdef ROUTE_SEQ_REPEAT_EN
              rep_inc = 1'b1;
`endif
              nxt     = next_phase(IDLE, MAX_CNT_W'(len0_q), MAX_CNT_W'(len1_q), MAX_CNT_W'(len2_q));
              state_d = nxt;
              sel_d   = phase_sel(nxt);
              last_d  = final_beat(nxt, '0, len0_q, len1_q, len2_q, rep_next_last);
            end else begin
              state_d = FIN;
              valid_d = 1'b0;
              sel_d   = SEL_NONE;
              last_d  = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end
      FIN: begin
        // An empty pass reaches FIN still busy, so done is raised on the way out.
        state_d = IDLE;
        valid_d = 1'b0;
        sel_d   = SEL_NONE;
        last_d  = 1'b0;
        done_d  = busy_q;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        sel_d   = SEL_NONE;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, latched lengths and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= SEL_NONE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      len0_q  <= '0;
      len1_q  <= '0;
      len2_q  <= '0;
`ifdef ROUTE_SEQ_REPEAT_EN
      reps_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      len0_q  <= len0_d;
      len1_q  <= len1_d;
      len2_q  <= len2_d;
`ifdef ROUTE_SEQ_REPEAT_EN
      reps_q  <= reps_d;
`endif
    end
  end

  assign sel   = sel_q;
  assign addr  = addr_cnt;
  assign valid = valid_q;
  assign last  = last_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_route_seq.sv
// Self-checking bench for route_seq: expected beats are queued per pass and
// popped as the DUT transfers them.
module tb_route_seq;

  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset, start, ready;
  logic [CW-1:0] len0, len1, len2;
`ifdef ROUTE_SEQ_REPEAT_EN
  logic [CW-1:0] reps;
`endif
  logic [1:0]    sel;
  logic [CW-1:0] addr;
  logic          valid, last, busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]    sel;
    logic [CW-1:0] addr;
    logic          last;
  } beat_t;

  beat_t exp_q[$];

  always #5 clk = ~clk;

  route_seq #(.CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .len0  (len0),
    .len1  (len1),
    .len2  (len2),
`ifdef ROUTE_SEQ_REPEAT_EN
    .reps  (reps),
`endif
    .ready (ready),
    .sel   (sel),
    .addr  (addr),
    .valid (valid),
    .last  (last),
    .busy  (busy),
    .done  (done)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected beat sequence for a whole start request.
  task automatic push_pass(input int l0, input int l1, input int l2, input int r);
    int lens[3];
    int nr;
    beat_t b;
    lens[0] = l0; lens[1] = l1; lens[2] = l2;
    nr = (r == 0) ? 1 : r;
    for (int p = 0; p < nr; p++)
      for (int s = 0; s < 3; s++)
        for (int a = 0; a < lens[s]; a++) begin
          b.sel  = 2'(s);
          b.addr = CW'(a);
          b.last = 1'b0;
          exp_q.push_back(b);
        end
    if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;
  endtask

  task automatic do_start(input int l0, input int l1, input int l2, input int r);
    len0 = CW'(l0);
    len1 = CW'(l1);
    len2 = CW'(l2);
`ifdef ROUTE_SEQ_REPEAT_EN
    reps = CW'(r);
`else
    if (r > 1) $display("note: reps=%0d ignored in single-pass build", r);
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Consume beats (mode 0: ready always high, mode 1: ready high every third cycle).
  task automatic drain(input string name, input int mode, input int budget);
    int    k;
    bit    fin;
    bit    hold;
    beat_t held;
    beat_t got;
    beat_t e;
    k = 0; fin = 0; hold = 0; held = '0;
    while (!fin && k < budget) begin
      ready = (mode == 0) ? 1'b1 : (k % 3 == 0);
      got = {sel, addr, last};
      if (hold) begin
        checks++;
        if (got !== held || valid !== 1'b1) begin
          errors++;
          $display("FAIL %s hold: got sel=%0d addr=%0d last=%0d valid=%0d, need sel=%0d addr=%0d last=%0d valid=1",
                   name, sel, addr, last, valid, held.sel, held.addr, held.last);
        end
      end
      hold = 0;
      checks++;
      if (valid !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s streaming k=%0d: got valid=%0d done=%0d busy=%0d, need 1/0/1",
                 name, k, valid, done, busy);
      end
      if (valid === 1'b1 && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s extra beat: got sel=%0d addr=%0d, need no beat", name, sel, addr);
          fin = 1;
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (got !== e) begin
            errors++;
            $display("FAIL %s beat: got sel=%0d addr=%0d last=%0d, need sel=%0d addr=%0d last=%0d",
                     name, sel, addr, last, e.sel, e.addr, e.last);
          end
          if (exp_q.size() == 0) fin = 1;
        end
      end else if (valid === 1'b1) begin
        hold = 1;
        held = got;
      end
      tick();
      k++;
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL %s timeout: got %0d beats outstanding, need 0", name, exp_q.size());
      exp_q.delete();
    end else if (done !== 1'b1 || busy !== 1'b0 || valid !== 1'b0 || sel !== 2'b11 || last !== 1'b0) begin
      errors++;
      $display("FAIL %s done: got done=%0d busy=%0d valid=%0d sel=%0d last=%0d, need 1/0/0/3/0",
               name, done, busy, valid, sel, last);
    end
    tick();
    checks++;
    if (done !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL %s done width: got done=%0d valid=%0d, need 0/0", name, done, valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ready = 1'b0;
    len0 = '0; len1 = '0; len2 = '0;
`ifdef ROUTE_SEQ_REPEAT_EN
    reps = '0;
`endif
    tick(); tick();
    checks++;
    if ({sel, addr, valid, last, busy, done} !== {2'b11, CW'(0), 4'b0000}) begin
      errors++;
      $display("FAIL reset: got sel=%0d addr=%0d valid=%0d last=%0d busy=%0d done=%0d, need 3/0/0/0/0/0",
               sel, addr, valid, last, busy, done);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    push_pass(3, 2, 1, 1);
    ready = 1'b1;
    do_start(3, 2, 1, 1);
    checks++;
    if (valid !== 1'b1 || sel !== 2'b00 || addr !== CW'(0)) begin
      errors++;
      $display("FAIL latency: got valid=%0d sel=%0d addr=%0d, need 1/0/0", valid, sel, addr);
    end
    drain("basic", 0, 50);
  endtask

  task automatic test_skip();
    push_pass(2, 0, 1, 1);
    do_start(2, 0, 1, 1);
    drain("skip", 0, 50);
    push_pass(0, 3, 0, 1);
    do_start(0, 3, 0, 1);
    drain("skip_src1_only", 0, 50);
  endtask

  task automatic test_empty();
    ready = 1'b1;
    do_start(0, 0, 0, 1);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || sel !== 2'b11) begin
      errors++;
      $display("FAIL empty N+1: got valid=%0d busy=%0d done=%0d sel=%0d, need 0/1/0/3", valid, busy, done, sel);
    end
    tick();
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL empty N+2: got valid=%0d busy=%0d done=%0d, need 0/0/1", valid, busy, done);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty N+3: got done=%0d busy=%0d, need 0/0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    push_pass(4, 0, 0, 1);
    do_start(4, 0, 0, 1);
    drain("backpressure", 1, 100);
    push_pass(1, 2, 2, 1);
    do_start(1, 2, 2, 1);
    drain("backpressure_mix", 1, 100);
  endtask

  task automatic test_reset_mid();
    int k;
    ready = 1'b1;
    do_start(3, 4, 1, 1);
    k = 0;
    while (sel !== 2'b01 && k < 20) begin
      tick();
      k++;
    end
    checks++;
    if (sel !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid reach SRC1: got sel=%0d, need 1", sel);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({sel, addr, valid, last, busy, done} !== {2'b11, CW'(0), 4'b0000}) begin
      errors++;
      $display("FAIL reset_mid: got sel=%0d addr=%0d valid=%0d last=%0d busy=%0d done=%0d, need 3/0/0/0/0/0",
               sel, addr, valid, last, busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid quiet: got done=%0d valid=%0d, need 0/0", done, valid);
      end
    end
    push_pass(1, 2, 1, 1);
    do_start(1, 2, 1, 1);
    drain("after_reset", 0, 50);
  endtask

  task automatic test_start_busy();
    push_pass(2, 1, 1, 1);
    do_start(2, 1, 1, 1);
    ready = 1'b0;
    start = 1'b1;
    len0 = CW'(7); len1 = CW'(5); len2 = CW'(6);
    tick();
    start = 1'b0;
    drain("start_busy", 0, 50);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL start_busy extra pass: got valid=%0d busy=%0d, need 0/0", valid, busy);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    push_pass(2, 2, 2, 1);
    do_start(2, 2, 2, 1);
    drain("b2b_first", 0, 50);
    push_pass(1, 0, 3, 1);
    do_start(1, 0, 3, 1);
    drain("b2b_second", 0, 50);
  endtask

`ifdef ROUTE_SEQ_REPEAT_EN
  task automatic test_repeat();
    push_pass(1, 1, 1, 2);
    do_start(1, 1, 1, 2);
    drain("repeat2", 0, 50);
    push_pass(2, 0, 1, 0);
    do_start(2, 0, 1, 0);
    drain("repeat0", 1, 100);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_skip();
    test_empty();
    test_backpressure();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
`ifdef ROUTE_SEQ_REPEAT_EN
    test_repeat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
